// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types, width helpers and default thresholds for param_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEF_AE_TH     = 2;
    localparam int DEF_AF_MARGIN = 2;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module      : fifo_ram
// Description : DEPTH x DATA_W storage; registered read port in standard mode,
//               combinational read port in first-word-fall-through mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram
    import fifo_pkg::*;
#(
    parameter int         DATA_W = 8,
    parameter int         DEPTH  = 16,
    parameter fifo_mode_e MODE   = FIFO_STD
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         we,
    input  logic [ptr_width(DEPTH)-1:0]  waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         re,
    input  logic [ptr_width(DEPTH)-1:0]  raddr,
    output logic [DATA_W-1:0]            rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word is presented directly; pop/clear only move pointers upstream.
            logic w_unused;
            assign w_unused = ^{rst_n, clr, re};
            assign rdata    = r_mem[raddr];
        end else begin : g_std
            logic [DATA_W-1:0] r_dout;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout <= '0;
                end else if (clr) begin
                    r_dout <= '0;
                end else if (re) begin
                    r_dout <= r_mem[raddr];
                end
            end
            assign rdata = r_dout;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/param_fifo.sv
// ============================================================================
// Module      : param_fifo
// Description : Parametrised single-clock FIFO with standard/FWFT read mode,
//               programmable almost flags, occupancy count and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int FWFT   = 0,
    parameter int AF_TH  = DEPTH - DEF_AF_MARGIN,
    parameter int AE_TH  = DEF_AE_TH
)(
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         srst_in,
    input  logic                         wr_en_in,
    input  logic [DATA_W-1:0]            din_in,
    input  logic                         rd_en_in,
    output logic [DATA_W-1:0]            dout_out,
    output logic                         full_out,
    output logic                         empty_out,
    output logic                         almost_full_out,
    output logic                         almost_empty_out,
    output logic [cnt_width(DEPTH)-1:0]  count_out,
    output logic                         overflow_out,
    output logic                         underflow_out
);

    localparam int         PTR_W = ptr_width(DEPTH);
    localparam int         CNT_W = cnt_width(DEPTH);
    localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_TH);

    generate
        if ((DEPTH < 2) || (DEPTH > 1024) || ((DEPTH & (DEPTH - 1)) != 0) ||
            (DATA_W < 1) || (DATA_W > 64) || (AE_TH < 0) ||
            (AE_TH >= AF_TH) || (AF_TH > DEPTH)) begin : g_param_check
            $error("param_fifo: illegal DEPTH/DATA_W/threshold parameters");
        end
    endgenerate

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic w_rd_acc;
    logic w_wr_acc;
    logic w_empty;

    assign w_empty  = (r_count == '0);
    assign w_rd_acc = rd_en_in & ~w_empty;
    // A full FIFO still takes a write when the same edge pops a word.
    assign w_wr_acc = wr_en_in & ((r_count != FULL_CNT) | w_rd_acc);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (srst_in) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= wr_en_in & ~w_wr_acc;
            r_underflow <= rd_en_in & w_empty;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .MODE   (MODE)
    ) u_ram (
        .clk    (clk_in),
        .rst_n  (rst_n_in),
        .clr    (srst_in),
        .we     (w_wr_acc & ~srst_in),
        .waddr  (r_wptr),
        .wdata  (din_in),
        .re     (w_rd_acc),
        .raddr  (r_rptr),
        .rdata  (dout_out)
    );

    assign count_out        = r_count;
    assign empty_out        = w_empty;
    assign full_out         = (r_count == FULL_CNT);
    assign almost_full_out  = (r_count >= AF_CNT);
    assign almost_empty_out = (r_count <= AE_CNT);
    assign overflow_out     = r_overflow;
    assign underflow_out    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_param_fifo.sv
// ============================================================================
// Module      : tb_param_fifo
// Description : Directed bench for param_fifo (standard 8x16 and FWFT 8x4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_fifo;

    typedef struct {
        bit         wr;
        logic [7:0] din;
        bit         rd;
        bit         srst;
        int         cnt;
        logic [7:0] dout;
        bit         empty;
        bit         full;
        bit         af;
        bit         ae;
        bit         ov;
        bit         un;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       s_srst = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
    logic [7:0] s_din = '0;
    logic [7:0] s_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;
    logic [4:0] s_count;

    logic       f_srst = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] f_din = '0;
    logic [7:0] f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [2:0] f_count;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    param_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk_in(clk), .rst_n_in(rst_n), .srst_in(s_srst),
        .wr_en_in(s_wr), .din_in(s_din), .rd_en_in(s_rd),
        .dout_out(s_dout), .full_out(s_full), .empty_out(s_empty),
        .almost_full_out(s_af), .almost_empty_out(s_ae), .count_out(s_count),
        .overflow_out(s_ov), .underflow_out(s_un)
    );

    param_fifo #(.DATA_W(8), .DEPTH(4), .FWFT(1), .AF_TH(2), .AE_TH(1)) u_fw (
        .clk_in(clk), .rst_n_in(rst_n), .srst_in(f_srst),
        .wr_en_in(f_wr), .din_in(f_din), .rd_en_in(f_rd),
        .dout_out(f_dout), .full_out(f_full), .empty_out(f_empty),
        .almost_full_out(f_af), .almost_empty_out(f_ae), .count_out(f_count),
        .overflow_out(f_ov), .underflow_out(f_un)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags for the 16-deep instance follow from the expected count alone.
    function automatic void add(bit wr, logic [7:0] din, bit rd, bit srst,
                                int cnt, logic [7:0] dout, bit ov, bit un);
        vec_t v;
        v.wr = wr; v.din = din; v.rd = rd; v.srst = srst;
        v.cnt = cnt; v.dout = dout; v.ov = ov; v.un = un;
        v.empty = (cnt == 0);
        v.full  = (cnt == 16);
        v.af    = (cnt >= 14);
        v.ae    = (cnt <= 2);
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] d;

        for (int i = 1; i <= 16; i++) add(1, 8'(i), 0, 0, i, 8'h00, 0, 0);
        add(1, 8'd17, 0, 0, 16, 8'h00, 1, 0);
        add(0, 8'h00, 0, 0, 16, 8'h00, 0, 0);
        for (int k = 1; k <= 16; k++) add(0, 8'h00, 1, 0, 16 - k, 8'(k), 0, 0);
        add(0, 8'h00, 1, 0, 0, 8'd16, 0, 1);
        add(0, 8'h00, 0, 0, 0, 8'd16, 0, 0);
        add(1, 8'h55, 1, 0, 1, 8'd16, 0, 1);
        add(0, 8'h00, 1, 0, 0, 8'h55, 0, 0);
        for (int i = 0; i < 16; i++) add(1, 8'(8'h20 + i), 0, 0, i + 1, 8'h55, 0, 0);
        add(1, 8'hAA, 1, 0, 16, 8'h20, 0, 0);
        for (int k = 1; k <= 15; k++) add(0, 8'h00, 1, 0, 16 - k, 8'(8'h20 + k), 0, 0);
        add(0, 8'h00, 1, 0, 0, 8'hAA, 0, 0);
        for (int i = 1; i <= 7; i++) add(1, 8'(i), 0, 0, i, 8'hAA, 0, 0);
        add(1, 8'h99, 0, 1, 0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 0, 0, 8'h00, 0, 1);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        check("std_reset_count", s_count, 0);
        check("std_reset_empty", s_empty, 1);
        check("std_reset_ae", s_ae, 1);
        check("std_reset_af", s_af, 0);
        check("std_reset_full", s_full, 0);
        check("std_reset_dout", s_dout, 0);
        check("std_reset_errs", {s_ov, s_un}, 0);
        check("fw_reset_empty", f_empty, 1);

        foreach (vecs[n]) begin
            s_wr = vecs[n].wr; s_din = vecs[n].din;
            s_rd = vecs[n].rd; s_srst = vecs[n].srst;
            tick();
            check($sformatf("v%0d_count", n), s_count, vecs[n].cnt);
            check($sformatf("v%0d_dout", n), s_dout, vecs[n].dout);
            check($sformatf("v%0d_flags", n), {s_empty, s_full, s_af, s_ae},
                  {vecs[n].empty, vecs[n].full, vecs[n].af, vecs[n].ae});
            check($sformatf("v%0d_errs", n), {s_ov, s_un}, {vecs[n].ov, vecs[n].un});
        end
        s_wr = 0; s_rd = 0; s_srst = 0;

        // Asynchronous reset mid-run, observed before any further clock edge.
        for (int i = 0; i < 5; i++) begin
            s_wr = 1; s_din = 8'(8'h61 + i);
            tick();
        end
        s_wr = 0; s_rd = 1;
        tick();
        s_rd = 0;
        check("pre_arst_dout", s_dout, 8'h61);
        check("pre_arst_count", s_count, 4);
        rst_n = 1'b0;
        #1;
        check("arst_count", s_count, 0);
        check("arst_empty", s_empty, 1);
        check("arst_ae", s_ae, 1);
        check("arst_dout", s_dout, 0);
        check("arst_full", s_full, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // FWFT: head word visible while not empty, next word after a pop.
        f_wr = 1; f_din = 8'h11;
        tick();
        f_wr = 0;
        check("fw_w1_dout", f_dout, 8'h11);
        check("fw_w1_empty", f_empty, 0);
        check("fw_w1_count", f_count, 1);
        check("fw_w1_ae_af", {f_ae, f_af}, 2'b10);
        f_wr = 1; f_din = 8'h22;
        tick();
        f_wr = 0;
        check("fw_w2_dout", f_dout, 8'h11);
        check("fw_w2_ae_af", {f_ae, f_af}, 2'b01);
        f_rd = 1;
        tick();
        f_rd = 0;
        check("fw_pop_dout", f_dout, 8'h22);
        check("fw_pop_count", f_count, 1);
        f_rd = 1;
        tick();
        f_rd = 0;
        check("fw_drain_empty", f_empty, 1);

        f_wr = 1; f_din = 8'h30;
        tick();
        for (int i = 1; i <= 10; i++) begin
            d = 8'(8'h30 + i);
            f_wr = 1; f_rd = 1; f_din = d;
            tick();
            check($sformatf("fw_wrap%0d_dout", i), f_dout, d);
            check($sformatf("fw_wrap%0d_count", i), f_count, 1);
        end
        f_wr = 0; f_rd = 1;
        tick();
        f_rd = 0;
        check("fw_wrap_end_empty", f_empty, 1);
        check("fw_wrap_end_errs", {f_ov, f_un}, 0);
        f_rd = 1;
        tick();
        f_rd = 0;
        check("fw_underflow", f_un, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
